// File: rtl/serial_pkg.sv
// Shared line-level definitions for the serial transmitter/receiver pair.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // A line that is not being driven reads as idle.
  function automatic logic line_bit(input logic ser_in, input logic ser_en);
    return ser_en ? ser_in : IDLE_LEVEL;
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with zero flag, used to count data bits in a frame.
module bit_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/serial_receiver.sv
// Serial deserialiser: start bit, DATA_W bits LSB-first, stop bit, valid/ready output.
// Optional even-parity checking is enabled by defining PARITY_CHECK_EN.
module serial_receiver
  import serial_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_en,
  output logic [DATA_W-1:0] par_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
`ifdef PARITY_CHECK_EN
  output logic              parity_err,
`endif
  output logic              overrun,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state, next_state;
  logic              b;
  logic [DATA_W-1:0] shreg;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              shift_en, commit, ferr_set;
`ifdef PARITY_CHECK_EN
  logic              par_sample, perr_set, par_bad;
`endif

  assign b    = line_bit(ser_in, ser_en);
  assign busy = (state != IDLE);

  bit_down_counter #(
    .CNT_W(CNT_W)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(LAST_BIT),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    ferr_set   = 1'b0;
`ifdef PARITY_CHECK_EN
    par_sample = 1'b0;
    perr_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (b == START_LEVEL) begin
          next_state = DATA;
          cnt_load   = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (cnt_zero) begin
`ifdef PARITY_CHECK_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PARITY: begin
`ifdef PARITY_CHECK_EN
        par_sample = 1'b1;
`endif
        next_state = STOP;
      end
      STOP: begin
        if (b == IDLE_LEVEL) begin
          next_state = IDLE;
`ifdef PARITY_CHECK_EN
          perr_set   = par_bad;
          commit     = !par_bad;
`else
          commit     = 1'b1;
`endif
        end else begin
          // A low stop bit may mean a stuck line; wait for it to recover.
          ferr_set   = 1'b1;
          next_state = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (b == IDLE_LEVEL) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {b, shreg[DATA_W-1:1]};
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (par_sample) par_bad <= (^shreg) ^ b;
  end

  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_set;
  end
`endif

  // Output register: a commit that coincides with an accept replaces the word cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_out   <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (commit) begin
        par_out   <= shreg;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed frame table, corner sequences, random stream.
module tb_serial_receiver;

  localparam int DATA_W = 8;
`ifdef PARITY_CHECK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N = 3000;

  logic              clk = 1'b0;
  logic              rst, ser_in, ser_en, out_ready;
  logic [DATA_W-1:0] par_out;
  logic              out_valid, frame_err, overrun, busy;
`ifdef PARITY_CHECK_EN
  logic              parity_err;
`endif

  serial_receiver #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_en    (ser_en),
    .par_out   (par_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
`ifdef PARITY_CHECK_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic si, input logic en, input logic rdy, input logic r);
    ser_in = si; ser_en = en; out_ready = rdy; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop, input logic rdy,
                            input logic rdy_stop, input logic par_flip);
    tick(1'b0, 1'b1, rdy, 1'b0);
    for (int i = 0; i < DATA_W; i++) tick(d[i], 1'b1, rdy, 1'b0);
    if (PAR != 0) tick((^d) ^ par_flip, 1'b1, rdy, 1'b0);
    tick(stop, 1'b1, rdy_stop, 1'b0);
  endtask

  typedef struct {
    logic              rst_before;
    logic [DATA_W-1:0] data;
    logic              stop;
    logic              rdy;
    logic              rdy_stop;
    int                low_after;
    int                idle_after;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_word;
    logic              exp_ferr;
    logic              exp_ovr;
  } vec_t;

  vec_t tbl[9];

  // Random stream and its expected per-edge outcome.
  logic              si_a[N], en_a[N], b_a[N], rdy_a[N];
  logic              e_commit[N], e_ferr[N], e_perr[N], e_busy[N];
  logic [DATA_W-1:0] e_word[N];
  int                p;

  task automatic put(input logic bv);
    if (bv && $urandom_range(0, 5) == 0) begin
      en_a[p] = 1'b0;
      si_a[p] = 1'($urandom_range(0, 1));
    end else begin
      en_a[p] = 1'b1;
      si_a[p] = bv;
    end
    b_a[p] = bv;
    p++;
  endtask

  task automatic run_random(input int mode);
    logic [DATA_W-1:0] d, w;
    logic stop, par_ok, ov, ovr;
    logic [DATA_W-1:0] po;
    int gap, lows, i, j, last;
    p = 0;
    while (p < N - 30) begin
      gap = $urandom_range(0, 3);
      repeat (gap) put(1'b1);
      d = DATA_W'($urandom);
      put(1'b0);
      for (int k = 0; k < DATA_W; k++) put(d[k]);
      if (PAR != 0) put((^d) ^ ($urandom_range(0, 7) == 0));
      stop = ($urandom_range(0, 7) != 0);
      put(stop);
      if (!stop) begin
        lows = $urandom_range(0, 3);
        repeat (lows) put(1'b0);
      end
    end
    while (p < N) put(1'b1);
    for (int k = 0; k < N; k++) begin
      rdy_a[k]    = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      e_commit[k] = 1'b0; e_ferr[k] = 1'b0; e_perr[k] = 1'b0; e_busy[k] = 1'b0;
      e_word[k]   = '0;
    end
    // Parse the line as frames: start, data, optional parity, stop, stuck-low recovery.
    i = 0;
    while (i < N) begin
      if (b_a[i]) begin
        i++;
        continue;
      end
      last = i + DATA_W + 1 + PAR;
      if (last >= N) break;
      for (int k = i; k < last; k++) e_busy[k] = 1'b1;
      for (int k = 0; k < DATA_W; k++) w[k] = b_a[i + 1 + k];
      par_ok = (PAR == 0) ? 1'b1 : (((^w) ^ b_a[i + 1 + DATA_W]) == 1'b0);
      if (b_a[last]) begin
        if (par_ok) begin
          e_commit[last] = 1'b1;
          e_word[last]   = w;
        end else begin
          e_perr[last] = 1'b1;
        end
        i = last + 1;
      end else begin
        e_ferr[last] = 1'b1;
        e_busy[last] = 1'b1;
        j = last + 1;
        while (j < N && !b_a[j]) begin
          e_busy[j] = 1'b1;
          j++;
        end
        i = j + 1;
      end
    end
    do_reset();
    ov = 1'b0; ovr = 1'b0; po = '0;
    for (int k = 0; k < N; k++) begin
      tick(si_a[k], en_a[k], rdy_a[k], 1'b0);
      if (e_commit[k]) begin
        if (ov && !rdy_a[k]) ovr = 1'b1;
        ov = 1'b1;
        po = e_word[k];
      end else if (ov && rdy_a[k]) begin
        ov = 1'b0;
      end
      check("rnd_valid", out_valid, ov);
      check("rnd_par_out", par_out, po);
      check("rnd_frame_err", frame_err, e_ferr[k]);
      check("rnd_overrun", overrun, ovr);
      check("rnd_busy", busy, e_busy[k]);
`ifdef PARITY_CHECK_EN
      check("rnd_parity_err", parity_err, e_perr[k]);
`endif
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 8'h81, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 0, 1, 1'b1, 8'hC3, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 8'h7E, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h12, 1'b1, 1'b1, 1'b1, 0, 1, 1'b1, 8'h12, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 3, 1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0, 1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 0, 1, 1'b1, 8'h55, 1'b0, 1'b0};

    // Reset state and first-frame latency.
    do_reset();
    check("rst_valid", out_valid, 1'b0);
    check("rst_par_out", par_out, '0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    d = 8'h0A;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("lat_busy_start", busy, 1'b1);
    for (int i = 0; i < DATA_W; i++) tick(d[i], 1'b1, 1'b0, 1'b0);
    if (PAR != 0) tick(^d, 1'b1, 1'b0, 1'b0);
    check("lat_valid_early", out_valid, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("lat_valid", out_valid, 1'b1);
    check("lat_par_out", par_out, 8'h0A);
    check("lat_busy_end", busy, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("accept_valid", out_valid, 1'b0);
    check("accept_par_out", par_out, 8'h0A);

    for (int v = 0; v < 9; v++) begin
      if (tbl[v].rst_before) do_reset();
      send_frame(tbl[v].data, tbl[v].stop, tbl[v].rdy, tbl[v].rdy_stop, 1'b0);
      check("tbl_valid", out_valid, tbl[v].exp_valid);
      check("tbl_par_out", par_out, tbl[v].exp_word);
      check("tbl_frame_err", frame_err, tbl[v].exp_ferr);
      check("tbl_overrun", overrun, tbl[v].exp_ovr);
      repeat (tbl[v].low_after) tick(1'b0, 1'b1, tbl[v].rdy, 1'b0);
      repeat (tbl[v].idle_after) tick(1'b1, 1'b1, tbl[v].rdy, 1'b0);
      if (tbl[v].idle_after > 0) check("tbl_idle_busy", busy, 1'b0);
    end

    // Bad stop bit followed by a stuck-low line.
    do_reset();
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ferr_pulse", frame_err, 1'b1);
    check("ferr_busy", busy, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("ferr_one_cycle", frame_err, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("wait_hi_busy", busy, 1'b1);
    check("wait_hi_valid", out_valid, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("wait_hi_exit", busy, 1'b0);

    // Reset in the middle of a frame.
    do_reset();
    d = 8'hF0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(d[i], 1'b1, 1'b0, 1'b0);
    tick(d[4], 1'b1, 1'b0, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", out_valid, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst_idle", busy, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_valid2", out_valid, 1'b1);
    check("midrst_word", par_out, 8'h55);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_ovr", overrun, 1'b0);

`ifdef PARITY_CHECK_EN
    do_reset();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    check("par_good_valid", out_valid, 1'b1);
    check("par_good_word", par_out, 8'h07);
    check("par_good_perr", parity_err, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    check("par_bad_perr", parity_err, 1'b1);
    check("par_bad_valid", out_valid, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("par_bad_pulse", parity_err, 1'b0);
    check("par_bad_busy", busy, 1'b0);
`endif

    run_random(0);
    run_random(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
